// File: rtl/dmux8_scheduler.sv
// ---------------------------------------------------------------------------
// dmux8_scheduler
//
// Round-robin distributor that sequences an 8-way demultiplexer. A single
// producer hands items over a valid/ready handshake. Each accepted item is
// held in a one-entry buffer and steered to the next enabled consumer
// channel, searching cyclically from a rotating pointer.
//
// Optional build macro: DMUX8_SCHED_STATS_EN
//   When defined, adds a 16-bit wrapping count of output transfers
//   (xfer_count) and a registered stall flag (stall).
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   reset      : synchronous, active-high reset
//   in_valid   : producer offers in_data
//   in_data    : producer item (WIDTH bits)
//   in_ready   : scheduler takes in_data this cycle (combinational)
//   chan_en    : per-channel enable mask
//   out_ready  : per-consumer ready
//   out_valid  : one-hot (or zero) valid towards the consumers
//   out_data   : buffered item, shared by all channels
//   sel        : demux select, index of the addressed channel
//   busy       : buffer holds an item
//   xfer_count : (stats build) count of output transfers
//   stall      : (stats build) previous cycle held an item nobody took
// ---------------------------------------------------------------------------
module dmux8_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [7:0]       chan_en,
    input  logic [7:0]       out_ready,
    output logic [7:0]       out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       sel,
`ifdef DMUX8_SCHED_STATS_EN
    output logic [15:0]      xfer_count,
    output logic             stall,
`endif
    output logic             busy
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_ptr;
    logic [2:0]       w_ptr_nxt;
    logic [2:0]       r_sel;
    logic [2:0]       w_sel_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic [7:0]       r_out_valid;
    logic [7:0]       w_out_valid_nxt;
    logic             r_busy;

    logic             w_no_tgt;
    logic             w_out_xfer;
    logic             w_in_ready;
    logic             w_in_xfer;
    logic [2:0]       w_base;
    logic [3:0]       w_tgt_res;
    logic [2:0]       w_tgt;

    // Cyclic first-one search starting at base. Result is {found, index}.
    // Iterating from the farthest offset down lets the nearest hit win.
    function automatic logic [3:0] find_tgt(input logic [2:0] base,
                                            input logic [7:0] mask);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = base + k[2:0];
            if (mask[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign w_no_tgt   = (chan_en == 8'h00);
    assign w_out_xfer = (r_state == ST_FULL) & out_ready[r_sel];
    // A slot freed this cycle may be refilled at once, giving 1 item/cycle.
    assign w_in_ready = ~reset & ~w_no_tgt & ((r_state == ST_EMPTY) | w_out_xfer);
    assign w_in_xfer  = in_valid & w_in_ready;
    // The new item's search starts after the channel that is draining now.
    assign w_base     = w_out_xfer ? (r_sel + 3'd1) : r_ptr;
    assign w_tgt_res  = find_tgt(w_base, chan_en);
    assign w_tgt      = w_tgt_res[2:0];

    // Next-state, buffer and select computation.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_data_nxt  = r_data;
        w_ptr_nxt   = r_ptr;
        if (w_out_xfer) begin
            w_ptr_nxt = r_sel + 3'd1;
        end else begin
            w_ptr_nxt = r_ptr;
        end
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = ST_FULL;
                    w_data_nxt  = in_data;
                    w_sel_nxt   = w_tgt;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_xfer && w_in_xfer) begin
                    w_state_nxt = ST_FULL;
                    w_data_nxt  = in_data;
                    w_sel_nxt   = w_tgt;
                end else if (w_out_xfer) begin
                    // sel deliberately keeps its last value when emptying
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (w_state_nxt == ST_FULL) begin
            w_out_valid_nxt = 8'd1 << w_sel_nxt;
        end else begin
            w_out_valid_nxt = 8'h00;
        end
    end

    // State, buffer, pointer and registered output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_ptr       <= 3'd0;
            r_sel       <= 3'd0;
            r_data      <= '0;
            r_out_valid <= 8'h00;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_sel       <= w_sel_nxt;
            r_data      <= w_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= (w_state_nxt == ST_FULL);
        end
    end

`ifdef DMUX8_SCHED_STATS_EN
    logic [15:0] r_xfer_count;
    logic        r_stall;

    // Transfer counter (wraps naturally) and stall flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_xfer_count <= 16'd0;
            r_stall      <= 1'b0;
        end else begin
            if (w_out_xfer) begin
                r_xfer_count <= r_xfer_count + 16'd1;
            end else begin
                r_xfer_count <= r_xfer_count;
            end
            r_stall <= (r_state == ST_FULL) & ~out_ready[r_sel];
        end
    end

    assign xfer_count = r_xfer_count;
    assign stall      = r_stall;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_data;
    assign sel       = r_sel;
    assign busy      = r_busy;

endmodule

// File: tb/tb_dmux8_scheduler.sv
module tb_dmux8_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] chan_en;
    logic [7:0] out_ready;
    logic [7:0] out_valid;
    logic [7:0] out_data;
    logic [2:0] sel;
    logic       busy;
`ifdef DMUX8_SCHED_STATS_EN
    logic [15:0] xfer_count;
    logic        stall;
`endif

    always #5 clk = ~clk;

    dmux8_scheduler #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .chan_en    (chan_en),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .sel        (sel),
`ifdef DMUX8_SCHED_STATS_EN
        .xfer_count (xfer_count),
        .stall      (stall),
`endif
        .busy       (busy)
    );

    int nchecks = 0;
    int nerr    = 0;

    // reference model state
    bit         m_full = 1'b0;
    logic [2:0] m_ptr  = 3'd0;
    logic [2:0] m_sel  = 3'd0;
    bit         m_acc  = 1'b0;
    int         m_total = 0;
    logic [15:0] m_xcnt = 16'd0;
    logic        m_stall = 1'b0;
    logic [7:0] q_data[$];
    logic [2:0] q_sel[$];
    logic [2:0] obs_sel[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] search(input logic [2:0] base, input logic [7:0] mask);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (mask[3'(base + k)]) begin
                r = 3'(base + k);
                break;
            end
        end
        return r;
    endfunction

    // One clock: check at the falling edge, advance the model, step past the rising edge.
    task automatic tick();
        bit         exp_ready;
        bit         oxfer;
        logic [2:0] base;
        logic [7:0] ed;
        logic [2:0] es;
        @(negedge clk);
        exp_ready = !reset && (chan_en != 8'h00) && (!m_full || out_ready[m_sel]);
        check("in_ready", in_ready, exp_ready);
        check("busy", busy, m_full);
        check("out_valid", out_valid, m_full ? (8'd1 << m_sel) : 8'd0);
        check("sel", sel, m_sel);
`ifdef DMUX8_SCHED_STATS_EN
        check("stall", stall, m_stall);
        check("xfer_count", xfer_count, m_xcnt);
`endif
        if (!reset && ((out_valid & out_ready) != 8'h00)) begin
            if (q_data.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                ed = q_data.pop_front();
                es = q_sel.pop_front();
                check("out_data", out_data, ed);
                check("out_sel", sel, es);
                obs_sel.push_back(sel);
            end
        end
        oxfer = m_full && out_ready[m_sel] && !reset;
        m_acc = in_valid && exp_ready;
        if (reset) begin
            m_full = 1'b0; m_ptr = 3'd0; m_sel = 3'd0; m_stall = 1'b0; m_xcnt = 16'd0;
            q_data.delete(); q_sel.delete();
        end else begin
            m_stall = m_full && !out_ready[m_sel];
            base = oxfer ? 3'(m_sel + 3'd1) : m_ptr;
            if (oxfer) begin
                m_ptr = 3'(m_sel + 3'd1);
                m_total++;
                m_xcnt = m_xcnt + 16'd1;
            end
            if (m_acc) begin
                m_sel  = search(base, chan_en);
                m_full = 1'b1;
                q_data.push_back(in_data);
                q_sel.push_back(m_sel);
            end else if (oxfer) begin
                m_full = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int n, input logic [7:0] base);
        int i = 0;
        int budget = 200;
        while (i < n && budget > 0) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            tick();
            if (m_acc) i++;
            budget--;
        end
        in_valid = 1'b0;
        check("send_budget", (budget > 0), 1'b1);
    endtask

    task automatic drain();
        int budget = 50;
        in_valid = 1'b0;
        while ((q_data.size() != 0 || m_full) && budget > 0) begin
            tick();
            budget--;
        end
        check("drain_budget", (budget > 0), 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        chan_en   = 8'hFF;
        out_ready = 8'hFF;
        @(posedge clk);
        #1;
        do_reset();

        // 1: all channels, back-to-back, wrap on the 9th item
        obs_sel.delete();
        send_n(9, 8'h10);
        drain();
        check("t1_count", obs_sel.size(), 9);
        for (int i = 0; i < 9 && i < obs_sel.size(); i++)
            check("t1_sel_walk", obs_sel[i], i % 8);

        // 2: sparse mask 1010_0100
        do_reset();
        chan_en = 8'b1010_0100;
        obs_sel.delete();
        send_n(4, 8'h40);
        drain();
        check("t2_count", obs_sel.size(), 4);
        if (obs_sel.size() == 4) begin
            check("t2_sel0", obs_sel[0], 3'd2);
            check("t2_sel1", obs_sel[1], 3'd5);
            check("t2_sel2", obs_sel[2], 3'd7);
            check("t2_sel3", obs_sel[3], 3'd2);
        end

        // 3: stall with in_valid held, then release channel 0
        do_reset();
        chan_en   = 8'hFF;
        out_ready = 8'h00;
        in_valid  = 1'b1;
        in_data   = 8'hA1;
        tick();
        in_data = 8'hA2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_stall_ready", in_ready, 1'b0);
            check("t3_stall_data", out_data, 8'hA1);
        end
        out_ready = 8'h01;
        tick();
        in_valid  = 1'b0;
        out_ready = 8'h00;
        tick();
        check("t3_sel", sel, 3'd1);
        check("t3_data", out_data, 8'hA2);
        out_ready = 8'hFF;
        drain();

        // 4: held item on channel 3 survives a cleared mask
        do_reset();
        chan_en   = 8'b0000_1000;
        out_ready = 8'h00;
        send_n(1, 8'h33);
        check("t4_sel", sel, 3'd3);
        chan_en   = 8'h00;
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        in_data   = 8'h34;
        obs_sel.delete();
        tick();
        tick();
        check("t4_delivered_ch", (obs_sel.size() == 1) ? obs_sel[0] : 3'd0, 3'd3);
        check("t4_blocked", in_ready, 1'b0);
        chan_en = 8'hFF;
        tick();
        in_valid = 1'b0;
        check("t4_resume_sel", sel, 3'd4);
        drain();

        // 5: reset while FULL on channel 5
        do_reset();
        chan_en   = 8'h20;
        out_ready = 8'h00;
        send_n(1, 8'h55);
        check("t5_sel5", sel, 3'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_valid", out_valid, 8'h00);
        check("t5_busy", busy, 1'b0);
        check("t5_sel0", sel, 3'd0);
        chan_en   = 8'hFF;
        out_ready = 8'hFF;
        obs_sel.delete();
        send_n(1, 8'h56);
        drain();
        check("t5_first_ch", (obs_sel.size() == 1) ? obs_sel[0] : 3'd7, 3'd0);

`ifdef DMUX8_SCHED_STATS_EN
        // 6: counter wrap after 70000 transfers, then a stall
        begin
            int budget = 71000;
            do_reset();
            m_total   = 0;
            chan_en   = 8'hFF;
            out_ready = 8'hFF;
            in_valid  = 1'b1;
            while (m_total < 70000 && budget > 0) begin
                in_data = in_data + 8'd1;
                tick();
                budget--;
            end
            check("t6_budget", (budget > 0), 1'b1);
            in_valid  = 1'b0;
            out_ready = 8'h00;
            tick();
            check("t6_count", xfer_count, 16'd4464);
            tick();
            check("t6_stall", stall, 1'b1);
            out_ready = 8'hFF;
            drain();
        end
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
